// File: rtl/calc_pkg.sv
// Shared definitions for the two-function calculator: operand width,
// key codes and the sequencer state encoding.
package calc_pkg;

  localparam int W = 8;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2,
    S_ERR = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational W-bit two's complement add/subtract. Operands are widened
// by one sign bit so the two top bits of the wide result disagree exactly
// when the true result does not fit in W bits.
module calc_alu
  import calc_pkg::*;
(
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  logic signed [W:0] a_x;
  logic signed [W:0] b_x;
  logic signed [W:0] wide;

  function automatic logic ovf_of(input logic signed [W:0] s);
    return s[W] ^ s[W-1];
  endfunction

  // Sign-extend, add or subtract, then flag results outside the W-bit range
  always_comb begin
    a_x  = {a[W-1], a};
    b_x  = {b[W-1], b};
    wide = sub ? (a_x - b_x) : (a_x + b_x);
    sum  = wide[W-1:0];
    ovf  = ovf_of(wide);
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: turns key presses into an A <op> B = sequence,
// keeps the running result, and drives the display and error flags.
// A press is the rising edge of trig, so a held key acts once.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                trig,
  input  logic [3:0]          value,
  input  logic signed [W-1:0] iu_out,
  input  logic                valid,
  output logic signed [W-1:0] disp_val,
  output logic                err,
  output logic                ovf,
  output logic                op_sub,
  output logic [1:0]          state,
  output logic                entry_clr
);

  state_t              cur, nxt;
  logic                trig_d, press;
  logic signed [W-1:0] op_a, op_a_nxt;
  logic signed [W-1:0] result, result_nxt;
  logic signed [W-1:0] alu_sum;
  logic                alu_ovf;
  logic                op_sub_nxt, err_nxt, ovf_nxt, clr_nxt;

  assign press = trig & ~trig_d;
  assign state = cur;

  calc_alu u_alu (
    .a   (op_a),
    .b   (iu_out),
    .sub (op_sub),
    .sum (alu_sum),
    .ovf (alu_ovf)
  );

  // State and datapath registers; everything returns to idle on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= S_A;
      trig_d    <= 1'b0;
      op_a      <= '0;
      result    <= '0;
      op_sub    <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      entry_clr <= 1'b0;
    end else begin
      cur       <= nxt;
      trig_d    <= trig;
      op_a      <= op_a_nxt;
      result    <= result_nxt;
      op_sub    <= op_sub_nxt;
      err       <= err_nxt;
      ovf       <= ovf_nxt;
      entry_clr <= clr_nxt;
    end
  end

  // Next-state and register updates, acting only in the press cycle
  always_comb begin
    nxt        = cur;
    op_a_nxt   = op_a;
    result_nxt = result;
    op_sub_nxt = op_sub;
    err_nxt    = err;
    ovf_nxt    = ovf;
    clr_nxt    = 1'b0;
    if (press) begin
      if (value == KEY_CLR) begin
        nxt        = S_A;
        op_a_nxt   = '0;
        result_nxt = '0;
        op_sub_nxt = 1'b0;
        err_nxt    = 1'b0;
        ovf_nxt    = 1'b0;
        clr_nxt    = 1'b1;
      end else begin
        case (cur)
          S_A: begin
            if (is_op(value)) begin
              if (valid) begin
                op_a_nxt   = iu_out;
                op_sub_nxt = (value == KEY_SUB);
                clr_nxt    = 1'b1;
                nxt        = S_B;
              end else begin
                err_nxt = 1'b1;
                nxt     = S_ERR;
              end
            end
          end
          S_B: begin
            if (is_op(value)) begin
              op_sub_nxt = (value == KEY_SUB);
            end else if (value == KEY_EQ) begin
              if (!valid) begin
                err_nxt = 1'b1;
                nxt     = S_ERR;
              end else if (alu_ovf) begin
                // Overflowed result is discarded; the old result stays
                ovf_nxt = 1'b1;
                err_nxt = 1'b1;
                nxt     = S_ERR;
              end else begin
                result_nxt = alu_sum;
                clr_nxt    = 1'b1;
                nxt        = S_RES;
              end
            end
          end
          S_RES: begin
            if (is_op(value)) begin
              // Chain: the previous result becomes operand A; entry is already clear
              op_a_nxt   = result;
              op_sub_nxt = (value == KEY_SUB);
              nxt        = S_B;
            end else if (is_digit(value)) begin
              // The input unit keeps this digit as the start of a new entry
              ovf_nxt = 1'b0;
              nxt     = S_A;
            end
          end
          S_ERR: begin
          end
          default: nxt = S_A;
        endcase
      end
    end
  end

  // Display selection: live entry while typing, result after equals, blank on error
  always_comb begin
    disp_val = '0;
    case (cur)
      S_A, S_B: disp_val = iu_out;
      S_RES:    disp_val = result;
      default:  disp_val = '0;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scenario bench for calc_sequencer. Each step presses one key with a given
// entry; the expected output snapshot and entry_clr pulse count are queued
// when the press is driven and compared when the DUT has responded.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              trig;
  logic [3:0]        value;
  logic signed [7:0] iu_out;
  logic              valid;
  logic signed [7:0] disp_val;
  logic              err, ovf, op_sub, entry_clr;
  logic [1:0]        state;

  int checks = 0;
  int errors = 0;

  // snapshot layout: {state[1:0], disp_val[7:0], err, ovf, op_sub, entry_clr}
  typedef struct {
    logic [3:0]  key;
    logic [7:0]  entry;
    logic        vld;
    int          hold;
    logic [13:0] snap;
    int          clr;
  } step_t;

  step_t exp_q[$];

  calc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig),
    .value     (value),
    .iu_out    (iu_out),
    .valid     (valid),
    .disp_val  (disp_val),
    .err       (err),
    .ovf       (ovf),
    .op_sub    (op_sub),
    .state     (state),
    .entry_clr (entry_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic step_t st(input logic [3:0] k, input logic [7:0] en, input logic v,
                               input int h, input logic [1:0] s, input logic [7:0] d,
                               input logic e, input logic o, input logic os, input logic c);
    step_t r;
    r.key   = k;
    r.entry = en;
    r.vld   = v;
    r.hold  = h;
    r.snap  = {s, d, e, o, os, c};
    r.clr   = c ? 1 : 0;
    return r;
  endfunction

  // Press one key for 'hold' clock edges; return the outputs just after the
  // press edge and the number of cycles entry_clr was seen high.
  task automatic do_press(input logic [3:0] key, input logic [7:0] entry, input logic vld,
                          input int hold, output logic [13:0] snap, output int cnt);
    @(negedge clk);
    value  = key;
    iu_out = entry;
    valid  = vld;
    trig   = 1'b1;
    cnt    = 0;
    snap   = '0;
    for (int i = 0; i < hold + 2; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) snap = {state, disp_val, err, ovf, op_sub, entry_clr};
      if (entry_clr) cnt++;
      if (i == hold - 1) trig = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [13:0] snap;
    reset  = 1'b0;
    trig   = 1'b0;
    value  = 4'h0;
    iu_out = 8'sd0;
    valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    snap = {state, disp_val, err, ovf, op_sub, entry_clr};
    checks++;
    if (snap !== 14'h0) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", snap, 14'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_add();
    step_t s[$];
    step_t e;
    logic [13:0] snap;
    int cnt;
    s.push_back(st(KEY_ADD, 8'd12, 1, 1, S_B,   8'h0C, 0, 0, 0, 1));
    s.push_back(st(KEY_EQ,  8'd5,  1, 1, S_RES, 8'h11, 0, 0, 0, 1));
    foreach (s[i]) begin
      exp_q.push_back(s[i]);
      do_press(s[i].key, s[i].entry, s[i].vld, s[i].hold, snap, cnt);
      e = exp_q.pop_front();
      checks++;
      if (snap !== e.snap) begin errors++; $display("FAIL add[%0d] outputs: got %h want %h", i, snap, e.snap); end
      checks++;
      if (cnt !== e.clr) begin errors++; $display("FAIL add[%0d] entry_clr pulses: got %0d want %0d", i, cnt, e.clr); end
    end
  endtask

  task automatic test_max();
    step_t s[$];
    step_t e;
    logic [13:0] snap;
    int cnt;
    s.push_back(st(4'd1,    8'd100, 1, 1, S_A,   8'h64, 0, 0, 0, 0));
    s.push_back(st(KEY_ADD, 8'd100, 1, 1, S_B,   8'h64, 0, 0, 0, 1));
    s.push_back(st(KEY_EQ,  8'd27,  1, 1, S_RES, 8'h7F, 0, 0, 0, 1));
    foreach (s[i]) begin
      exp_q.push_back(s[i]);
      do_press(s[i].key, s[i].entry, s[i].vld, s[i].hold, snap, cnt);
      e = exp_q.pop_front();
      checks++;
      if (snap !== e.snap) begin errors++; $display("FAIL max[%0d] outputs: got %h want %h", i, snap, e.snap); end
      checks++;
      if (cnt !== e.clr) begin errors++; $display("FAIL max[%0d] entry_clr pulses: got %0d want %0d", i, cnt, e.clr); end
    end
  endtask

  task automatic test_overflow();
    step_t s[$];
    step_t e;
    logic [13:0] snap;
    int cnt;
    s.push_back(st(4'd1,    8'h9C, 1, 1, S_A,   8'h9C, 0, 0, 0, 0));
    s.push_back(st(KEY_SUB, 8'h9C, 1, 1, S_B,   8'h9C, 0, 0, 1, 1));
    s.push_back(st(KEY_EQ,  8'd50, 1, 1, S_ERR, 8'h00, 1, 1, 1, 0));
    s.push_back(st(4'd3,    8'd50, 1, 1, S_ERR, 8'h00, 1, 1, 1, 0));
    s.push_back(st(KEY_CLR, 8'd0,  1, 1, S_A,   8'h00, 0, 0, 0, 1));
    foreach (s[i]) begin
      exp_q.push_back(s[i]);
      do_press(s[i].key, s[i].entry, s[i].vld, s[i].hold, snap, cnt);
      e = exp_q.pop_front();
      checks++;
      if (snap !== e.snap) begin errors++; $display("FAIL overflow[%0d] outputs: got %h want %h", i, snap, e.snap); end
      checks++;
      if (cnt !== e.clr) begin errors++; $display("FAIL overflow[%0d] entry_clr pulses: got %0d want %0d", i, cnt, e.clr); end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    step_t e;
    logic [13:0] snap;
    int cnt;
    s.push_back(st(KEY_ADD, 8'd3, 1, 1, S_B,   8'h03, 0, 0, 0, 1));
    s.push_back(st(KEY_EQ,  8'd4, 1, 1, S_RES, 8'h07, 0, 0, 0, 1));
    s.push_back(st(KEY_ADD, 8'd0, 1, 1, S_B,   8'h00, 0, 0, 0, 0));
    s.push_back(st(KEY_EQ,  8'd2, 1, 5, S_RES, 8'h09, 0, 0, 0, 1));
    foreach (s[i]) begin
      exp_q.push_back(s[i]);
      do_press(s[i].key, s[i].entry, s[i].vld, s[i].hold, snap, cnt);
      e = exp_q.pop_front();
      checks++;
      if (snap !== e.snap) begin errors++; $display("FAIL chain[%0d] outputs: got %h want %h", i, snap, e.snap); end
      checks++;
      if (cnt !== e.clr) begin errors++; $display("FAIL chain[%0d] entry_clr pulses: got %0d want %0d", i, cnt, e.clr); end
    end
  endtask

  task automatic test_op_replace();
    step_t s[$];
    step_t e;
    logic [13:0] snap;
    int cnt;
    s.push_back(st(4'd1,    8'd10, 1, 1, S_A,   8'h0A, 0, 0, 0, 0));
    s.push_back(st(KEY_ADD, 8'd10, 1, 1, S_B,   8'h0A, 0, 0, 0, 1));
    s.push_back(st(KEY_SUB, 8'd0,  1, 1, S_B,   8'h00, 0, 0, 1, 0));
    s.push_back(st(KEY_EQ,  8'd3,  1, 1, S_RES, 8'h07, 0, 0, 1, 1));
    s.push_back(st(4'd2,    8'd0,  1, 1, S_A,   8'h00, 0, 0, 1, 0));
    s.push_back(st(KEY_ADD, 8'd0,  0, 1, S_ERR, 8'h00, 1, 0, 1, 0));
    s.push_back(st(KEY_CLR, 8'd0,  1, 1, S_A,   8'h00, 0, 0, 0, 1));
    foreach (s[i]) begin
      exp_q.push_back(s[i]);
      do_press(s[i].key, s[i].entry, s[i].vld, s[i].hold, snap, cnt);
      e = exp_q.pop_front();
      checks++;
      if (snap !== e.snap) begin errors++; $display("FAIL op_replace[%0d] outputs: got %h want %h", i, snap, e.snap); end
      checks++;
      if (cnt !== e.clr) begin errors++; $display("FAIL op_replace[%0d] entry_clr pulses: got %0d want %0d", i, cnt, e.clr); end
    end
  endtask

  task automatic test_async_reset();
    step_t s[$];
    step_t e;
    logic [13:0] snap;
    int cnt;
    @(negedge clk);
    value  = KEY_ADD;
    iu_out = 8'sd12;
    valid  = 1'b1;
    trig   = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (state !== 2'(S_B) || entry_clr !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got state=%0d entry_clr=%b want state=1 entry_clr=1", state, entry_clr);
    end
    #1;
    reset = 1'b0;
    #1;
    snap = {state, disp_val, err, ovf, op_sub, entry_clr};
    checks++;
    if (snap !== {2'(S_A), 8'h0C, 4'b0000}) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", snap, {2'(S_A), 8'h0C, 4'b0000});
    end
    trig = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    s.push_back(st(KEY_ADD, 8'd5, 1, 1, S_B,   8'h05, 0, 0, 0, 1));
    s.push_back(st(KEY_EQ,  8'd1, 1, 1, S_RES, 8'h06, 0, 0, 0, 1));
    foreach (s[i]) begin
      exp_q.push_back(s[i]);
      do_press(s[i].key, s[i].entry, s[i].vld, s[i].hold, snap, cnt);
      e = exp_q.pop_front();
      checks++;
      if (snap !== e.snap) begin errors++; $display("FAIL after_reset[%0d] outputs: got %h want %h", i, snap, e.snap); end
      checks++;
      if (cnt !== e.clr) begin errors++; $display("FAIL after_reset[%0d] entry_clr pulses: got %0d want %0d", i, cnt, e.clr); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_max();
    test_overflow();
    test_back_to_back();
    test_op_replace();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
